ps2_mouse_ctrl: RTL and testbench
=================================

# ps2_mouse_ctrl

Sequencing controller for the PS/2 mouse path. It sits between the byte-level PS/2 receiver, the host-to-device byte transmitter and the tracking logic. It brings the mouse up: waits for the BAT result, enables data reporting and recovers with a reset command on timeout or bad response. It then assembles the 3-byte stream packets into button and signed X/Y movement outputs.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: idle limit in init/command states (500 ms at 100 MHz).
- `PKT_TIMEOUT_CYCLES`, default 2_000_000: maximum gap between bytes of one packet (20 ms).
- `MAX_RETRIES`, default 3: reset-command attempts before declaring error.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `rx_done` in 1: one-cycle pulse when the receiver has a valid byte.
- `rx_data` in 8: received byte, valid while `rx_done`=1.
- `tx_ready` in 1: transmitter idle and able to accept a byte.
- `tx_done` in 1: one-cycle pulse when the transmitted byte completed, including device line ack.
- `tx_start` out 1: one-cycle request to send `tx_data`.
- `tx_data` out 8: command byte.
- `packet_valid` out 1: one-cycle pulse when a new packet is available.
- `buttons` out 3: {middle, right, left}.
- `dx`, `dy` out 9 each: two's-complement movement, sign bit taken from byte 0.
- `init_done` out 1: high while streaming.
- `error` out 1: sticky; set when retries are exhausted.
- `state` out 4: current FSM state, for LED debug.

## Operation
- States and encodings:
  - WAIT_BAT=0, WAIT_ID=1, SEND_EN=2, WAIT_ACK=3.
  - SEND_RST=4, WAIT_RST_ACK=5.
  - PKT0=6, PKT1=7, PKT2=8, ERROR=9.
- WAIT_BAT: on `rx_done` with 0xAA, go to WAIT_ID. Any other byte, or timeout, is a failure.
- WAIT_ID: on 0x00, go to SEND_EN. Any other byte, or timeout, is a failure.
- SEND_EN: `tx_data`=0xF4. Pulse `tx_start` on the first cycle with `tx_ready`=1, then wait for `tx_done` and go to WAIT_ACK. A timeout is a failure.
- WAIT_ACK: on 0xFA, go to PKT0, set `init_done`=1 and clear the retry count. Any other byte, or timeout, is a failure.
- SEND_RST: same handshake as SEND_EN with 0xFF. On `tx_done`, go to WAIT_RST_ACK.
- WAIT_RST_ACK: on 0xFA, go to WAIT_BAT. Any other byte, or timeout, is a failure.
- Failure handling:
  - If retry count < MAX_RETRIES: increment the count and go to SEND_RST.
  - Otherwise go to ERROR.
- ERROR: `error`=1 and `init_done`=0. No further `tx_start`; all `rx_done` ignored. Only reset exits.
- PKT0: accept a byte only if bit3=1; latch it and go to PKT1. A byte with bit3=0 is discarded and the state stays PKT0 (resync).
- PKT1: latch byte 1 and go to PKT2.
- PKT2: on byte 2, register outputs and return to PKT0:
  - `buttons`=b0[2:0]
  - `dx`={b0[4], b1}
  - `dy`={b0[5], b2}
- Overflow bits b0[7:6] are ignored.
- In PKT1/PKT2, a gap greater than PKT_TIMEOUT_CYCLES discards the partial packet and returns to PKT0. It does not count as a failure.
- PKT0 has no timeout.
- `rx_done` during SEND_EN/SEND_RST is ignored.

## Timing
- Reset values:
  - state = WAIT_BAT; all outputs 0; `tx_data` = 0x00.
  - Retry count and timeout counter = 0.
- Timeout counter:
  - Clears on every state change and on every accepted `rx_done`; otherwise increments each cycle.
  - A failure fires when the counter == limit − 1, i.e. the limit is reached in exactly the limit number of idle cycles.
- `tx_start` is exactly one cycle per command. `tx_data` is set on entry to the SEND state and held until the next SEND state.
- `packet_valid`, `buttons`, `dx` and `dy` update on the clock edge after the `rx_done` of byte 2 (1-cycle latency).
- `buttons`, `dx` and `dy` hold their values between packets.
- `init_done` rises on the edge after the 0xFA `rx_done` in WAIT_ACK.
- If `rx_done` and a timeout occur in the same cycle, the byte wins.
- Asynchronous reset mid-packet or mid-command discards all progress immediately and returns to WAIT_BAT.

## Test plan
- Normal init: rx 0xAA, 0x00 -> a single `tx_start` with `tx_data`=0xF4 once `tx_ready`=1; `tx_done`, then rx 0xFA -> `init_done`=1, `state`=6.
- Packet: after init, rx 0x29, 0x05, 0xFE -> one `packet_valid` pulse one cycle after the third `rx_done`; `buttons`=3'b001, `dx`=9'h005, `dy`=9'h1FE (−2).
- Resync: rx 0x05 (dropped), then 0x08, 0x01, 0x02 -> exactly one packet with `dx`=9'h001, `dy`=9'h002, `buttons`=0.
- Init timeout recovery: no bytes for TIMEOUT_CYCLES (set to 1000 for the bench) -> `tx_start` with 0xFF; then `tx_done`, rx 0xFA, 0xAA, 0x00 -> 0xF4 sent; rx 0xFA -> `init_done`=1.
- Retry exhaustion: wrong byte 0x55 in WAIT_BAT repeatedly -> after MAX_RETRIES resets (3 × 0xFF), the next failure gives `error`=1, `state`=9, and no further `tx_start` for 10000 cycles.
- Packet gap / reset: rx 0x08, then silence beyond PKT_TIMEOUT_CYCLES -> no `packet_valid` and `state` returns to 6. Assert `reset`=0 mid-packet -> all outputs 0 and `state`=0 immediately.

Source files
------------

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse sequencer: BAT/ID check, enable reporting with reset-command retries,
// then assembly of 3-byte stream packets into buttons and signed X/Y movement.
module ps2_mouse_ctrl #(
  parameter int TIMEOUT_CYCLES     = 50_000_000,
  parameter int PKT_TIMEOUT_CYCLES = 2_000_000,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       packet_valid,
  output logic [2:0] buttons,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       init_done,
  output logic       error,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    WAIT_BAT     = 4'd0,
    WAIT_ID      = 4'd1,
    SEND_EN      = 4'd2,
    WAIT_ACK     = 4'd3,
    SEND_RST     = 4'd4,
    WAIT_RST_ACK = 4'd5,
    PKT0         = 4'd6,
    PKT1         = 4'd7,
    PKT2         = 4'd8,
    ERROR        = 4'd9
  } state_t;

  localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] PKT_LIM = 32'(PKT_TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  MAX_R   = 8'(MAX_RETRIES);

  state_t      r_state;
  logic [31:0] r_tmo;
  logic [7:0]  r_retry;
  logic        r_tx_sent;
  logic        r_tx_start;
  logic [7:0]  r_tx_data;
  logic [2:0]  r_b0_btn;
  logic [1:0]  r_b0_sgn;
  logic [7:0]  r_b1;
  logic        r_packet_valid;
  logic [2:0]  r_buttons;
  logic [8:0]  r_dx;
  logic [8:0]  r_dy;
  logic        r_init_done;
  logic        r_error;

  state_t      w_next;
  state_t      w_fail_dst;
  logic        w_fail;
  logic        w_acc;
  logic        w_enter;
  logic        w_tmo_en;
  logic        w_tmo_hit;
  logic        w_send;
  logic [31:0] w_lim;

  // Timeout limit selection and failure destination
  always_comb begin
    w_tmo_en = 1'b1;
    w_lim    = TMO_LIM;
    if ((r_state == PKT1) || (r_state == PKT2)) begin
      w_lim = PKT_LIM;
    end else if ((r_state == PKT0) || (r_state == ERROR)) begin
      w_tmo_en = 1'b0;
    end else begin
      w_lim = TMO_LIM;
    end
    w_tmo_hit  = w_tmo_en && (r_tmo == w_lim);
    w_send     = (r_state == SEND_EN) || (r_state == SEND_RST);
    w_fail_dst = (r_retry < MAX_R) ? SEND_RST : ERROR;
  end

  // Next-state logic; a received byte always takes priority over a timeout
  always_comb begin
    w_next = r_state;
    w_fail = 1'b0;
    w_acc  = 1'b0;
    case (r_state)
      WAIT_BAT, WAIT_ID, WAIT_ACK, WAIT_RST_ACK: begin
        if (rx_done) begin
          w_acc = 1'b1;
          if ((r_state == WAIT_BAT) && (rx_data == 8'hAA)) begin
            w_next = WAIT_ID;
          end else if ((r_state == WAIT_ID) && (rx_data == 8'h00)) begin
            w_next = SEND_EN;
          end else if ((r_state == WAIT_ACK) && (rx_data == 8'hFA)) begin
            w_next = PKT0;
          end else if ((r_state == WAIT_RST_ACK) && (rx_data == 8'hFA)) begin
            w_next = WAIT_BAT;
          end else begin
            w_fail = 1'b1;
            w_next = w_fail_dst;
          end
        end else if (w_tmo_hit) begin
          w_fail = 1'b1;
          w_next = w_fail_dst;
        end else begin
          w_next = r_state;
        end
      end
      SEND_EN, SEND_RST: begin
        if (r_tx_sent && tx_done) begin
          w_next = (r_state == SEND_EN) ? WAIT_ACK : WAIT_RST_ACK;
        end else if (w_tmo_hit) begin
          w_fail = 1'b1;
          w_next = w_fail_dst;
        end else begin
          w_next = r_state;
        end
      end
      PKT0: begin
        if (rx_done) begin
          w_acc  = 1'b1;
          w_next = rx_data[3] ? PKT1 : PKT0;
        end else begin
          w_next = PKT0;
        end
      end
      PKT1, PKT2: begin
        if (rx_done) begin
          w_acc  = 1'b1;
          w_next = (r_state == PKT1) ? PKT2 : PKT0;
        end else if (w_tmo_hit) begin
          w_next = PKT0;
        end else begin
          w_next = r_state;
        end
      end
      ERROR:   w_next = ERROR;
      default: w_next = WAIT_BAT;
    endcase
    // A failure in SEND_RST re-enters the same state and must restart the command
    w_enter = w_fail || (w_next != r_state);
  end

  // State, timeout counter and retry count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= WAIT_BAT;
      r_tmo   <= 32'd0;
      r_retry <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_enter || w_acc) begin
        r_tmo <= 32'd0;
      end else if (w_tmo_en) begin
        r_tmo <= r_tmo + 32'd1;
      end else begin
        r_tmo <= r_tmo;
      end
      if ((r_state == WAIT_ACK) && (w_next == PKT0)) begin
        r_retry <= 8'd0;
      end else if (w_fail && (r_retry < MAX_R)) begin
        r_retry <= r_retry + 8'd1;
      end else begin
        r_retry <= r_retry;
      end
    end
  end

  // Command handshake: data loaded on entry, single start pulse per SEND visit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_sent  <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= w_send && !w_enter && !r_tx_sent && tx_ready;
      if (w_enter) begin
        r_tx_sent <= 1'b0;
      end else if (w_send && tx_ready) begin
        r_tx_sent <= 1'b1;
      end else begin
        r_tx_sent <= r_tx_sent;
      end
      if (w_enter && (w_next == SEND_EN)) begin
        r_tx_data <= 8'hF4;
      end else if (w_enter && (w_next == SEND_RST)) begin
        r_tx_data <= 8'hFF;
      end else begin
        r_tx_data <= r_tx_data;
      end
    end
  end

  // Packet assembly and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_b0_btn       <= 3'd0;
      r_b0_sgn       <= 2'd0;
      r_b1           <= 8'h00;
      r_packet_valid <= 1'b0;
      r_buttons      <= 3'd0;
      r_dx           <= 9'd0;
      r_dy           <= 9'd0;
      r_init_done    <= 1'b0;
      r_error        <= 1'b0;
    end else begin
      r_packet_valid <= 1'b0;
      if ((r_state == PKT0) && rx_done && rx_data[3]) begin
        r_b0_btn <= rx_data[2:0];
        r_b0_sgn <= rx_data[5:4];
      end else if ((r_state == PKT1) && rx_done) begin
        r_b1 <= rx_data;
      end else if ((r_state == PKT2) && rx_done) begin
        r_packet_valid <= 1'b1;
        r_buttons      <= r_b0_btn;
        r_dx           <= {r_b0_sgn[0], r_b1};
        r_dy           <= {r_b0_sgn[1], rx_data};
      end else begin
        r_b1 <= r_b1;
      end
      r_init_done <= (w_next == PKT0) || (w_next == PKT1) || (w_next == PKT2);
      r_error     <= r_error || (w_next == ERROR);
    end
  end

  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign packet_valid = r_packet_valid;
  assign buttons      = r_buttons;
  assign dx           = r_dx;
  assign dy           = r_dy;
  assign init_done    = r_init_done;
  assign error        = r_error;
  assign state        = r_state;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed bench for ps2_mouse_ctrl: init, packets, resync, timeouts, retries, reset.
module tb_ps2_mouse_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       packet_valid;
  logic [2:0] buttons;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       init_done;
  logic       error;
  logic [3:0] state;

  int         vectors    = 0;
  int         miscompares = 0;
  int         tx_cnt     = 0;
  int         pv_cnt     = 0;
  logic [7:0] tx_last    = 8'h00;
  int         base;

  ps2_mouse_ctrl #(
    .TIMEOUT_CYCLES    (1000),
    .PKT_TIMEOUT_CYCLES(200),
    .MAX_RETRIES       (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .packet_valid(packet_valid),
    .buttons     (buttons),
    .dx          (dx),
    .dy          (dy),
    .init_done   (init_done),
    .error       (error),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled 2 ns after each rising edge
  always @(posedge clk) begin
    #2;
    if (tx_start) begin
      tx_cnt  <= tx_cnt + 1;
      tx_last <= tx_data;
    end
    if (packet_valid) pv_cnt <= pv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // Bounded wait for one tx_start, then confirm no second pulse and the byte sent
  task automatic wait_tx(input int b, input logic [7:0] exp_data, input string tag);
    int n = 0;
    while ((tx_cnt == b) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_cnt"}, 32'(tx_cnt - b), 32'd1);
    check({tag, "_data"}, {24'd0, tx_last}, {24'd0, exp_data});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    rx_done  = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    tx_done  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_outs", {14'd0, tx_start, packet_valid, init_done, error, buttons, tx_data, 4'd0},
          32'd0);
    check("rst_dxdy", {14'd0, dx, dy}, 32'd0);
    reset = 1'b1;

    // Normal init, transmitter initially busy
    send_byte(8'hAA);
    check("wait_id", {28'd0, state}, 32'd1);
    send_byte(8'h00);
    check("send_en", {28'd0, state}, 32'd2);
    check("en_data", {24'd0, tx_data}, 32'h0000_00F4);
    base = tx_cnt;
    repeat (5) @(negedge clk);
    check("no_start_busy", 32'(tx_cnt - base), 32'd0);
    tx_ready = 1'b1;
    wait_tx(base, 8'hF4, "en");
    pulse_tx_done();
    check("wait_ack", {28'd0, state}, 32'd3);
    check("init_lo", {31'd0, init_done}, 32'd0);
    send_byte(8'hFA);
    check("init_hi", {31'd0, init_done}, 32'd1);
    check("pkt0", {28'd0, state}, 32'd6);

    // Packet 29 05 FE
    base = pv_cnt;
    send_byte(8'h29);
    send_byte(8'h05);
    check("pv_early", {31'd0, packet_valid}, 32'd0);
    send_byte(8'hFE);
    check("pv1", {31'd0, packet_valid}, 32'd1);
    check("btn1", {29'd0, buttons}, 32'd1);
    check("dx1", {23'd0, dx}, 32'h005);
    check("dy1", {23'd0, dy}, 32'h1FE);
    @(negedge clk);
    check("pv1_drop", {31'd0, packet_valid}, 32'd0);
    check("dx1_hold", {23'd0, dx}, 32'h005);
    check("pv1_cnt", 32'(pv_cnt - base), 32'd1);

    // Resync: 0x05 lacks bit3 and is discarded
    base = pv_cnt;
    send_byte(8'h05);
    check("resync_st", {28'd0, state}, 32'd6);
    send_byte(8'h08);
    send_byte(8'h01);
    send_byte(8'h02);
    check("btn2", {29'd0, buttons}, 32'd0);
    check("dx2", {23'd0, dx}, 32'h001);
    check("dy2", {23'd0, dy}, 32'h002);
    @(negedge clk);
    check("pv2_cnt", 32'(pv_cnt - base), 32'd1);

    // Packet gap: 200-cycle limit, boundary on both sides
    base = pv_cnt;
    send_byte(8'h08);
    check("gap_pkt1", {28'd0, state}, 32'd7);
    repeat (199) @(negedge clk);
    check("gap_before", {28'd0, state}, 32'd7);
    @(negedge clk);
    check("gap_after", {28'd0, state}, 32'd6);
    check("gap_init", {31'd0, init_done}, 32'd1);
    check("gap_no_pv", 32'(pv_cnt - base), 32'd0);

    // Asynchronous reset mid-packet
    send_byte(8'h08);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset_state", {28'd0, state}, 32'd0);
    check("areset_outs", {14'd0, tx_start, packet_valid, init_done, error, buttons, tx_data, 4'd0},
          32'd0);
    check("areset_dxdy", {14'd0, dx, dy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Init timeout (1000 idle cycles) -> reset command and full recovery
    repeat (999) @(negedge clk);
    check("tmo_before", {28'd0, state}, 32'd0);
    base = tx_cnt;
    @(negedge clk);
    check("tmo_after", {28'd0, state}, 32'd4);
    wait_tx(base, 8'hFF, "rst");
    pulse_tx_done();
    check("rst_ack_st", {28'd0, state}, 32'd5);
    send_byte(8'hFA);
    check("back_bat", {28'd0, state}, 32'd0);
    send_byte(8'hAA);
    send_byte(8'h00);
    base = tx_cnt;
    wait_tx(base, 8'hF4, "en2");
    pulse_tx_done();
    send_byte(8'hFA);
    check("recov_init", {31'd0, init_done}, 32'd1);
    check("recov_err", {31'd0, error}, 32'd0);

    // Retry exhaustion
    do_reset();
    base = tx_cnt;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h55);
      check("retry_st", {28'd0, state}, 32'd4);
      wait_tx(tx_cnt, 8'hFF, "retry");
      pulse_tx_done();
      send_byte(8'hFA);
    end
    check("retry_resets", 32'(tx_cnt - base), 32'd3);
    send_byte(8'h55);
    check("err_state", {28'd0, state}, 32'd9);
    check("err_flag", {31'd0, error}, 32'd1);
    check("err_init", {31'd0, init_done}, 32'd0);
    base = tx_cnt;
    send_byte(8'hAA);
    send_byte(8'hFA);
    repeat (10000) @(negedge clk);
    check("err_no_tx", 32'(tx_cnt - base), 32'd0);
    check("err_stuck", {28'd0, state}, 32'd9);
    check("err_sticky", {31'd0, error}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
